// File: rtl/w5300_bus_sequencer.sv
// W5300 bus sequencer: decoded 68008 access -> timed CS/RD/WR, DTACK, buffer controls, plus chip reset/ready sequence.
// Latency: DS seen 2 cycles after dsl; all outputs registered; DTACK held until DS releases, then strobes drop.
module w5300_bus_sequencer #(
  parameter int unsigned SETUP_CYCLES      = 1,
  parameter int unsigned STROBE_CYCLES     = 3,
  parameter int unsigned HOLD_CYCLES       = 1,
  parameter int unsigned RESET_LOW_CYCLES  = 20,
  parameter int unsigned RESET_WAIT_CYCLES = 200000,
  parameter int unsigned CNT_W             = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic dsl,
  input  logic rdwl,
  input  logic cardsel,
  input  logic rstsel,
  output logic dtack_drive,
  output logic dbenl,
  output logic dbdir,
  output logic wizcsl,
  output logic wizrdl,
  output logic wizwrl,
  output logic wizrstl,
  output logic wiz_ready
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACK, RST_ACK, RST_LOW, RST_WAIT
  } state_t;

  typedef struct packed {
    logic dtack;
    logic benl;
    logic dir;
    logic csl;
    logic rdl;
    logic wrl;
  } bus_t;

  localparam bus_t BUS_IDLE = '{dtack: 1'b0, benl: 1'b1, dir: 1'b1, csl: 1'b1, rdl: 1'b1, wrl: 1'b1};

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RLOW_LAST   = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RWAIT_LAST  = CNT_W'(RESET_WAIT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ds_meta_q;
  logic             ds_q;
  logic             rd_q;
  logic             rstl_q;
  logic             ready_q;
  bus_t             bus_q;
  logic             sel_any;

  assign sel_any = cardsel | rstsel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_LOW;
      cnt_q     <= '0;
      ds_meta_q <= 1'b0;
      ds_q      <= 1'b0;
      rd_q      <= 1'b1;
      rstl_q    <= 1'b0;
      ready_q   <= 1'b0;
      bus_q     <= BUS_IDLE;
    end else begin
      ds_meta_q <= ~dsl;
      ds_q      <= ds_meta_q;
      cnt_q     <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          // Reset register takes priority over the data window when both decode.
          if (ds_q && rstsel && !rdwl) begin
            state_q     <= RST_ACK;
            cnt_q       <= '0;
            bus_q.dtack <= 1'b1;
          end else if (ds_q && rstsel) begin
            state_q <= ACK;
            cnt_q   <= '0;
            bus_q   <= '{dtack: 1'b1, benl: 1'b0, dir: 1'b1, csl: 1'b1, rdl: 1'b1, wrl: 1'b1};
          end else if (ds_q && cardsel) begin
            state_q <= SETUP;
            cnt_q   <= '0;
            rd_q    <= rdwl;
            bus_q   <= '{dtack: 1'b0, benl: 1'b0, dir: rdwl, csl: 1'b0, rdl: 1'b1, wrl: 1'b1};
          end
        end
        SETUP: begin
          if (!ds_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= BUS_IDLE;
          end else if (cnt_q == SETUP_LAST) begin
            state_q   <= STROBE;
            cnt_q     <= '0;
            bus_q.rdl <= ~rd_q;
            bus_q.wrl <= rd_q;
          end
        end
        STROBE: begin
          if (!ds_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= BUS_IDLE;
          end else if (cnt_q == STROBE_LAST) begin
            cnt_q <= '0;
            if (rd_q) begin
              state_q     <= ACK;
              bus_q.dtack <= 1'b1;
            end else begin
              state_q   <= HOLD;
              bus_q.wrl <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!ds_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= BUS_IDLE;
          end else if (cnt_q == HOLD_LAST) begin
            state_q     <= ACK;
            cnt_q       <= '0;
            bus_q.dtack <= 1'b1;
          end
        end
        ACK: begin
          if (!ds_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= BUS_IDLE;
          end
        end
        RST_ACK: begin
          if (!ds_q) begin
            state_q <= RST_LOW;
            cnt_q   <= '0;
            rstl_q  <= 1'b0;
            ready_q <= 1'b0;
            bus_q   <= BUS_IDLE;
          end
        end
        RST_LOW: begin
          // CPU is still acknowledged while the chip is held in reset; no strobes reach it.
          bus_q.dtack <= ds_q & sel_any;
          if (cnt_q == RLOW_LAST) begin
            state_q <= RST_WAIT;
            cnt_q   <= '0;
            rstl_q  <= 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt_q == RWAIT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            bus_q   <= BUS_IDLE;
          end else begin
            bus_q.dtack <= ds_q & sel_any;
          end
        end
        default: begin
          state_q <= RST_LOW;
          cnt_q   <= '0;
          rstl_q  <= 1'b0;
          ready_q <= 1'b0;
          bus_q   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign dtack_drive = bus_q.dtack;
  assign dbenl       = bus_q.benl;
  assign dbdir       = bus_q.dir;
  assign wizcsl      = bus_q.csl;
  assign wizrdl      = bus_q.rdl;
  assign wizwrl      = bus_q.wrl;
  assign wizrstl     = rstl_q;
  assign wiz_ready   = ready_q;

endmodule

// File: tb/tb_w5300_bus_sequencer.sv
// Bench for w5300_bus_sequencer: per-cycle timeline model of each access plus directed tables and corner sequences.
module tb_w5300_bus_sequencer;
  localparam int S   = 1;
  localparam int T   = 3;
  localparam int H   = 1;
  localparam int RL  = 4;
  localparam int RW  = 8;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic reset, dsl, rdwl, cardsel, rstsel;
  logic dtack_drive, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, wiz_ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model of the current access: start cycle, edges dsl held low, kind, direction, handled normally?
  int   a_t0, a_n, a_kind;
  logic a_rd, a_live;
  int   lo_from, lo_until, ready_at;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  w5300_bus_sequencer #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H),
    .RESET_LOW_CYCLES(RL), .RESET_WAIT_CYCLES(RW), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .dsl(dsl), .rdwl(rdwl), .cardsel(cardsel), .rstsel(rstsel),
    .dtack_drive(dtack_drive), .dbenl(dbenl), .dbdir(dbdir), .wizcsl(wizcsl),
    .wizrdl(wizrdl), .wizwrl(wizwrl), .wizrstl(wizrstl), .wiz_ready(wiz_ready)
  );

  // Expected {dtack,dbenl,dbdir,csl,rdl,wrl,rstl,ready} after edge c.
  function automatic logic [7:0] model(int c);
    logic dt, be, dr, cs, rd, wr, rs, rdy;
    int k, e;
    dt = 0; be = 1; dr = 1; cs = 1; rd = 1; wr = 1;
    k = c - a_t0;
    e = a_n + 3;
    if (a_kind != 0 && k >= 3 && k < e) begin
      if (!a_live) begin
        if (a_kind != 4) dt = 1;
      end else begin
        case (a_kind)
          1: begin
            cs = 0; be = 0; dr = a_rd;
            if (k >= 3 + S) begin
              if (a_rd) rd = 0;
              else if (k < 3 + S + T) wr = 0;
            end
            if (k >= 3 + S + T + (a_rd ? 0 : H)) dt = 1;
          end
          2: begin be = 0; dt = 1; end
          3: dt = 1;
          default: ;
        endcase
      end
    end
    rs  = !(c >= lo_from && c < lo_until);
    rdy = !(c >= lo_from && c < ready_at);
    return {dt, be, dr, cs, rd, wr, rs, rdy};
  endfunction

  task automatic step(input string tag);
    logic [7:0] act, exp;
    @(negedge clk);
    act = {dtack_drive, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, wiz_ready};
    exp = model(cyc);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d outs=%b expected=%b", tag, cyc, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic run_access(input logic c_sel, input logic r_sel, input logic rw, input int n,
                            output int cs_fall, output int strb, output int dt_first, output int last_busy);
    cs_fall = 0; strb = 0; dt_first = 0; last_busy = 0;
    a_t0   = cyc;
    a_n    = n;
    a_rd   = rw;
    a_kind = r_sel ? (rw ? 2 : 3) : (c_sel ? 1 : 4);
    a_live = !(cyc + 3 >= lo_from && cyc + 3 < ready_at);
    if (a_live && a_kind == 3) begin
      lo_from  = cyc + n + 3;
      lo_until = lo_from + RL;
      ready_at = lo_until + RW;
    end
    cardsel = c_sel; rstsel = r_sel; rdwl = rw; dsl = 1'b0;
    for (int k = 1; k <= n + 5; k++) begin
      step("access");
      if (k == n) dsl = 1'b1;
      if (wizcsl === 1'b0 && cs_fall == 0) cs_fall = k;
      if (wizrdl === 1'b0 || wizwrl === 1'b0) strb++;
      if (dtack_drive === 1'b1 && dt_first == 0) dt_first = k;
      if (!wizcsl || !wizrdl || !wizwrl || !dbenl || dtack_drive) last_busy = k;
    end
  endtask

  typedef struct {
    logic c_sel, r_sel, rw;
    int   n, cs_fall, strb, dt_first, last_busy;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int cf, sb, df, lb, rel, rise_rst, rise_rdy, e_rst, rdy_cyc, n;
    logic c, r, rw;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 10, 3, 9, 7, 12};  // full read
    tbl[1] = '{1'b1, 1'b0, 1'b0, 10, 3, 3, 8, 12};  // full write
    tbl[2] = '{1'b1, 1'b0, 1'b1,  3, 3, 2, 0,  5};  // read aborted in strobe
    tbl[3] = '{1'b1, 1'b0, 1'b0,  5, 3, 3, 0,  7};  // write aborted in hold
    tbl[4] = '{1'b1, 1'b0, 1'b0,  6, 3, 3, 8,  8};  // write, single ack cycle
    tbl[5] = '{1'b0, 1'b1, 1'b1,  6, 0, 0, 3,  8};  // reset register read
    tbl[6] = '{1'b0, 1'b0, 1'b1,  6, 0, 0, 0,  0};  // no decode
    tbl[7] = '{1'b1, 1'b1, 1'b1,  4, 0, 0, 3,  6};  // both decoded, rstsel wins
    tbl[8] = '{1'b1, 1'b0, 1'b1,  1, 3, 0, 0,  3};  // glitch-short strobe
    tbl[9] = '{1'b1, 1'b0, 1'b1,  5, 3, 4, 7,  7};  // read, single ack cycle

    reset = 1; dsl = 1; rdwl = 1; cardsel = 0; rstsel = 0;
    a_kind = 0; a_t0 = 0; a_n = 0; a_rd = 1; a_live = 1;
    lo_from = 0; lo_until = BIG; ready_at = BIG;
    repeat (3) step("reset");

    reset = 0; rel = cyc; lo_until = rel + RL; ready_at = lo_until + RW;
    rise_rst = 0; rise_rdy = 0;
    for (int k = 1; k <= RL + RW + 3; k++) begin
      step("powerup");
      if (wizrstl && rise_rst == 0) rise_rst = k;
      if (wiz_ready && rise_rdy == 0) rise_rdy = k;
    end
    cmp("pwr_rstl_low", rise_rst, RL);
    cmp("pwr_ready", rise_rdy, RL + RW);

    for (int i = 0; i < 10; i++) begin
      run_access(tbl[i].c_sel, tbl[i].r_sel, tbl[i].rw, tbl[i].n, cf, sb, df, lb);
      cmp($sformatf("tbl%0d_cs_fall", i), cf, tbl[i].cs_fall);
      cmp($sformatf("tbl%0d_strobe", i), sb, tbl[i].strb);
      cmp($sformatf("tbl%0d_dtack", i), df, tbl[i].dt_first);
      cmp($sformatf("tbl%0d_busy", i), lb, tbl[i].last_busy);
    end

    // Reset write, then a data read inside the ready wait.
    run_access(1'b0, 1'b1, 1'b0, 4, cf, sb, df, lb);
    cmp("rstwr_dtack", df, 3);
    cmp("rstwr_no_cs", cf, 0);
    e_rst = lo_from;
    repeat (2) step("rstwin");
    run_access(1'b1, 1'b0, 1'b1, 2, cf, sb, df, lb);
    cmp("win_rd_no_cs", cf, 0);
    cmp("win_rd_dtack", df, 3);
    cmp("win_rd_busy", lb, 4);
    rdy_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step("rstwin");
      if (wiz_ready && rdy_cyc == 0) rdy_cyc = cyc;
    end
    cmp("win_ready_time", rdy_cyc - e_rst, RL + RW);

    for (int i = 0; i < 80; i++) begin
      c  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 12));
      if (cyc + 3 >= lo_from && cyc + 3 < ready_at && cyc + n + 5 >= ready_at)
        for (int k = 0; k < RL + RW + 4 && cyc < ready_at; k++) step("rand_wait");
      run_access(c, r, rw, n, cf, sb, df, lb);
    end

    // Synchronous reset while the write strobe is low.
    a_t0 = cyc; a_n = 1000; a_kind = 1; a_rd = 0; a_live = 1;
    cardsel = 1; rstsel = 0; rdwl = 0; dsl = 0;
    repeat (5) step("midwr");
    cmp("midwr_wr_low", int'(wizwrl), 0);
    reset = 1; dsl = 1; cardsel = 0;
    a_kind = 0; lo_from = cyc + 1; lo_until = BIG; ready_at = BIG;
    step("midwr_rst");
    cmp("midwr_wr_rel", int'(wizwrl), 1);
    cmp("midwr_cs_rel", int'(wizcsl), 1);
    cmp("midwr_rstl", int'(wizrstl), 0);
    step("midwr_rst");
    reset = 0; rel = cyc; lo_until = rel + RL; ready_at = lo_until + RW;
    rise_rdy = 0;
    for (int k = 1; k <= RL + RW + 3; k++) begin
      step("midwr_seq");
      if (wiz_ready && rise_rdy == 0) rise_rdy = k;
    end
    cmp("midwr_ready", rise_rdy, RL + RW);
    run_access(1'b1, 1'b0, 1'b1, 10, cf, sb, df, lb);
    cmp("post_rd_dtack", df, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w5300_bus_sequencer.md
Name: w5300_bus_sequencer

Overview:
Clocked sequencer between the QL expansion bus decode and the W5300. It turns a decoded 68008 access into timed W5300 CS/RD/WR strobes with programmable setup, strobe and hold lengths, and generates DTACK and the data-buffer controls. It also owns the W5300 reset sequence (power-up and software-triggered): a reset-low pulse followed by a ready wait, during which CPU accesses are still acknowledged.

Parameters:
SETUP_CYCLES, 1, clk cycles with CS low before RD/WR asserts (min 1)
STROBE_CYCLES, 3, clk cycles RD/WR held low before DTACK/hold (min 1)
HOLD_CYCLES, 1, write only: clk cycles CS low after WR rises (min 1)
RESET_LOW_CYCLES, 20, clk cycles wizrstl held low
RESET_WAIT_CYCLES, 200000, clk cycles after wizrstl rises before W5300 accesses are permitted
CNT_W, 24, shared counter width; must hold the largest cycle parameter

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high
dsl  in  1  raw 68008 data strobe, active low, asynchronous
rdwl  in  1  68008 R/W (1 = read), sampled on access start
cardsel  in  1  decoded W5300 data-window address hit
rstsel  in  1  decoded reset-register address hit
dtack_drive  out  1  1 = pull DTACK low (top level tristates otherwise)
dbenl  out  1  data buffer enable, active low
dbdir  out  1  data buffer direction, 1 = card to CPU
wizcsl  out  1  W5300 chip select, active low
wizrdl  out  1  W5300 read strobe, active low
wizwrl  out  1  W5300 write strobe, active low
wizrstl  out  1  W5300 reset, active low
wiz_ready  out  1  1 = reset sequence complete

Behaviour:
- dsl passes through a 2-flop synchroniser; ds = !dsl after sync, 2-cycle latency. All outputs are registered and decoded from the next state, so they change on the edge that enters a state.
- reset = 1: state RST_LOW, counter = 0, wizrstl = 0, wiz_ready = 0, wizcsl = wizrdl = wizwrl = 1, dbenl = 1, dbdir = 1, dtack_drive = 0, synchroniser cleared. Reset mid-access aborts at once; no strobe remains asserted.
- States: IDLE, SETUP, STROBE, HOLD, ACK, RST_ACK, RST_LOW, RST_WAIT.
- IDLE: ds & rstsel & !rdwl -> RST_ACK. Otherwise ds & cardsel -> SETUP, latching rd = rdwl. rstsel has priority if both are decoded. A read of rstsel -> ACK with no W5300 strobes; dbenl = 0 and returned data is don't-care.
- SETUP: wizcsl = 0, dbenl = 0, dbdir = rd. Stays SETUP_CYCLES cycles, then -> STROBE.
- STROBE: wizrdl = 0 if rd, else wizwrl = 0. Stays STROBE_CYCLES cycles. Then a read -> ACK with wizrdl still low; a write -> HOLD.
- HOLD (write only): wizwrl = 1, wizcsl = 0. Stays HOLD_CYCLES cycles, then -> ACK.
- ACK: dtack_drive = 1. CS and buffer remain as in the previous state; for a read, RD stays low. Leaves on !ds -> IDLE with all strobes released, dbenl = 1, dbdir = 1 on that edge.
- Abort: !ds in SETUP, STROBE or HOLD -> IDLE next edge; all strobes are released and no DTACK is issued.
- RST_ACK: dtack_drive = 1. On !ds -> RST_LOW, counter = 0.
- RST_LOW: wizrstl = 0 for RESET_LOW_CYCLES cycles, then -> RST_WAIT, counter = 0, wizrstl = 1.
- RST_WAIT: RESET_WAIT_CYCLES cycles, then -> IDLE with wiz_ready = 1. wiz_ready falls on entry to RST_LOW.
- Accesses during RST_LOW/RST_WAIT: dtack_drive = ds & (cardsel | rstsel), registered. No W5300 strobes and no buffer enable are generated. The counter keeps running. A reset write in this window does not restart the sequence.
- Counter: one CNT_W-bit up-counter, cleared on every state entry; a state exits when count == PARAM-1. Wrap is impossible by the parameter rule.
- Back-to-back accesses: ds must be seen low at least once (the ACK exit) before the next access starts.

Test Plan:
- Power-up, with sim parameters RESET_LOW = 4 and RESET_WAIT = 8: release reset -> wizrstl low exactly 4 cycles, then wiz_ready rises 8 cycles after wizrstl rises; all other outputs are at their reset values throughout.
- Read with cardsel, rdwl = 1, defaults: dsl falls -> wizcsl falls 3 edges later. wizrdl low 1 cycle after that, and dtack_drive = 1 after 3 strobe cycles with wizrdl still low. dsl rises -> all outputs idle 3 edges later.
- Write with rdwl = 0: CS low 1 cycle, then WR low 3 cycles, then WR high with CS low 1 cycle, then dtack_drive = 1. dbdir = 0 and dbenl = 0 throughout.
- Abort: dsl rises in the 2nd STROBE cycle -> strobes released, dtack_drive never asserted, IDLE reached; a following read completes normally.
- Reset write (rstsel, rdwl = 0) after ready -> DTACK, then on ds release wizrstl low 4 cycles and wiz_ready = 0. A cardsel read issued during RST_WAIT gets DTACK with wizcsl staying 1, and the wait is not extended.
- Sync reset asserted mid-write while WR is low -> wizwrl = 1 and wizcsl = 1 on the next edge, wizrstl = 0, and the reset sequence restarts.
